// File: rtl/dma_spi_tx.sv
// dma_spi_tx: SPI mode-0 frame transmitter (MSB first) with CS framing.
// Setup / shift / hold / gap phases are timed in clk_en ticks.
module dma_spi_tx #(
    parameter int N_BITS   = 408,
    parameter int HALF_DIV = 2,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int CS_GAP   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clk_en,
    input  logic [N_BITS-1:0] data_in,
    input  logic              start,
    input  logic              abort,
    output logic              MOSI,
    output logic              SCLK,
    output logic              CS,
    output logic              busy,
    output logic              done
);

    localparam int BW = $clog2(N_BITS + 1);

    localparam logic [7:0]    SETUP_END = 8'(CS_SETUP - 1);
    localparam logic [7:0]    HALF_END  = 8'(HALF_DIV - 1);
    localparam logic [7:0]    HOLD_END  = 8'(CS_HOLD - 1);
    localparam logic [7:0]    GAP_END   = 8'(CS_GAP - 1);
    localparam logic [BW-1:0] BIT_MAX   = BW'(N_BITS);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } state_t;

    state_t            state;
    logic [7:0]        tcnt;
    logic [BW-1:0]     bcnt;
    logic [N_BITS-1:0] sreg;

    // Frame sequencer; tcnt times every phase, including SCLK half-periods.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            tcnt  <= '0;
            bcnt  <= '0;
            sreg  <= '0;
            MOSI  <= 1'b0;
            SCLK  <= 1'b0;
            CS    <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            // done is a single-clk pulse even when ticks are gated off
            done <= 1'b0;
            if (abort && state != IDLE) begin
                state <= GAP;
                tcnt  <= '0;
                bcnt  <= '0;
                MOSI  <= 1'b0;
                SCLK  <= 1'b0;
                CS    <= 1'b1;
            end else if (clk_en) begin
                unique case (state)
                    IDLE: begin
                        if (start) begin
                            sreg  <= data_in;
                            MOSI  <= data_in[N_BITS-1];
                            CS    <= 1'b0;
                            busy  <= 1'b1;
                            tcnt  <= '0;
                            bcnt  <= '0;
                            state <= SETUP;
                        end
                    end
                    SETUP: begin
                        if (tcnt == SETUP_END) begin
                            tcnt  <= '0;
                            state <= SHIFT;
                        end else begin
                            tcnt <= tcnt + 8'd1;
                        end
                    end
                    SHIFT: begin
                        if (tcnt == HALF_END) begin
                            tcnt <= '0;
                            if (!SCLK) begin
                                SCLK <= 1'b1;
                                bcnt <= bcnt + 1'b1;
                            end else begin
                                SCLK <= 1'b0;
                                // data moves only on the falling edge
                                if (bcnt < BIT_MAX) begin
                                    sreg <= {sreg[N_BITS-2:0], 1'b0};
                                    MOSI <= sreg[N_BITS-2];
                                end else begin
                                    state <= HOLD;
                                end
                            end
                        end else begin
                            tcnt <= tcnt + 8'd1;
                        end
                    end
                    HOLD: begin
                        if (tcnt == HOLD_END) begin
                            tcnt  <= '0;
                            CS    <= 1'b1;
                            MOSI  <= 1'b0;
                            done  <= 1'b1;
                            state <= GAP;
                        end else begin
                            tcnt <= tcnt + 8'd1;
                        end
                    end
                    GAP: begin
                        if (tcnt == GAP_END) begin
                            tcnt  <= '0;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            tcnt <= tcnt + 8'd1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dma_spi_tx.sv
// tb_dma_spi_tx: directed table-driven bench for dma_spi_tx (defaults).
// A negedge monitor acts as an SPI mode-0 receiver and frame meter.
module tb_dma_spi_tx;

    localparam int N = 408;

    localparam logic [N-1:0] D0 = {64'h8000000000000001, 48'h1, 48'h2,
                                   32'h3, 64'h4, 16'h1, 8'h0, 32'h5,
                                   32'h6, 32'h7, 32'h8};
    localparam logic [N-1:0] D1 = {1'b1, 407'h0};
    localparam logic [N-1:0] D2 = {51{8'hA5}};
    localparam logic [N-1:0] D3 = {51{8'h3C}};

    logic         clk = 1'b0;
    logic         rst;
    logic         clk_en;
    logic [N-1:0] data_in;
    logic         start;
    logic         abort;
    logic         MOSI;
    logic         SCLK;
    logic         CS;
    logic         busy;
    logic         done;

    dma_spi_tx dut (
        .clk    (clk),
        .rst    (rst),
        .clk_en (clk_en),
        .data_in(data_in),
        .start  (start),
        .abort  (abort),
        .MOSI   (MOSI),
        .SCLK   (SCLK),
        .CS     (CS),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit tog    = 1'b0;

    // receiver / meter state, written only by the monitor
    int           cs_low_cnt  = 0;
    int           rises       = 0;
    int           done_cnt    = 0;
    int           viol        = 0;
    int           cs_high_run = 0;
    int           last_gap    = 0;
    logic [N-1:0] rx          = '0;
    logic         prev_sclk   = 1'b0;
    logic         prev_cs     = 1'b1;
    logic         prev_mosi   = 1'b0;

    // Sample outputs half a period away from the active edge.
    always @(negedge clk) begin
        if (!CS) cs_low_cnt++;
        if (done) done_cnt++;
        if (!prev_sclk && SCLK) begin
            rises++;
            rx = {rx[N-2:0], MOSI};
        end
        if (!CS && !prev_cs && MOSI != prev_mosi && !(prev_sclk && !SCLK))
            viol++;
        if (CS) begin
            cs_high_run++;
        end else begin
            if (prev_cs) last_gap = cs_high_run;
            cs_high_run = 0;
        end
        prev_sclk = SCLK;
        prev_cs   = CS;
        prev_mosi = MOSI;
    end

    typedef struct {
        logic [N-1:0] data;
        bit           tog;
        bit           poke;
        int           cs_low;
        int           rises;
        int           dones;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string nm, input logic [N-1:0] act,
                       input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (tog) clk_en = ~clk_en;
    endtask

    task automatic do_vec(input vec_t v, input string nm);
        int s_cs, s_r, s_d, s_v, n;
        tog     = v.tog;
        clk_en  = 1'b1;
        data_in = v.data;
        start   = 1'b1;
        n = 0;
        while (!busy && n < 8) begin
            tick();
            n++;
        end
        start = 1'b0;
        s_cs = cs_low_cnt;
        s_r  = rises;
        s_d  = done_cnt;
        s_v  = viol;
        chk({nm, "_accept"}, {busy, CS, SCLK, MOSI},
            {1'b1, 1'b0, 1'b0, v.data[N-1]});
        n = 0;
        while (busy && n < 10000) begin
            if (v.poke && (n == 10 || n == 500)) begin
                start   = 1'b1;
                data_in = ~v.data;
            end else begin
                start   = v.poke && n >= 1600;
                data_in = v.data;
            end
            tick();
            n++;
        end
        chk({nm, "_busy_end"}, busy, 0);
        chk({nm, "_cs_low"}, cs_low_cnt - s_cs, v.cs_low);
        chk({nm, "_rises"}, rises - s_r, v.rises);
        chk({nm, "_done"}, done_cnt - s_d, v.dones);
        chk({nm, "_rx"}, rx, v.data);
        chk({nm, "_mosi_edge"}, viol - s_v, 0);
        tog    = 1'b0;
        clk_en = 1'b1;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, s_r, s_d;
        logic [3:0] snap;

        vecs[0] = '{D0, 1'b0, 1'b0, 1636, 408, 1};
        vecs[1] = '{D1, 1'b0, 1'b0, 1636, 408, 1};
        vecs[2] = '{D0, 1'b1, 1'b0, 3272, 408, 1};
        vecs[3] = '{D2, 1'b0, 1'b0, 1636, 408, 1};
        vecs[4] = '{D3, 1'b0, 1'b1, 1636, 408, 1};

        rst     = 1'b1;
        clk_en  = 1'b0;
        start   = 1'b0;
        abort   = 1'b0;
        data_in = '0;
        tick();
        tick();
        chk("reset_state", {CS, SCLK, MOSI, busy, done}, 5'b10000);
        rst    = 1'b0;
        clk_en = 1'b1;
        repeat (3) tick();

        for (int i = 0; i < 5; i++)
            do_vec(vecs[i], $sformatf("vec%0d", i));

        // start held through the end of vec4: accepted only after GAP
        n = 0;
        while (!busy && n < 8) begin
            tick();
            n++;
        end
        start = 1'b0;
        chk("gap_accept", busy, 1);
        tick();
        // 4 GAP ticks plus the IDLE tick that samples start
        chk("gap_len", last_gap, 5);

        // abort after 100 SCLK rises of the frame just started
        s_r = rises;
        s_d = done_cnt;
        n = 0;
        while (rises - s_r < 100 && n < 2000) begin
            tick();
            n++;
        end
        chk("abort_reach", rises - s_r >= 100, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_out", {CS, SCLK, MOSI, busy, done}, 5'b10010);
        n = 0;
        while (busy && n < 20) begin
            tick();
            n++;
        end
        chk("abort_gap", n, 4);
        chk("abort_no_done", done_cnt - s_d, 0);
        repeat (2) tick();

        // freeze with clk_en low, then reset mid-SHIFT
        data_in = D2;
        start   = 1'b1;
        n = 0;
        while (!busy && n < 8) begin
            tick();
            n++;
        end
        start = 1'b0;
        repeat (200) tick();
        clk_en = 1'b0;
        tick();
        snap = {CS, SCLK, MOSI, busy};
        s_r  = rises;
        repeat (6) tick();
        chk("freeze_out", {CS, SCLK, MOSI, busy}, snap);
        chk("freeze_rises", rises - s_r, 0);
        clk_en = 1'b1;
        repeat (100) tick();
        s_d = done_cnt;
        rst = 1'b1;
        tick();
        chk("rst_mid", {CS, SCLK, MOSI, busy, done}, 5'b10000);
        rst = 1'b0;
        tick();
        chk("rst_no_done", done_cnt - s_d, 0);
        do_vec(vecs[0], "post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
